// File: rtl/clock_pkg.sv
// clock_pkg: shared unit indices, front-panel state enum and button priority order.
package clock_pkg;

    localparam int UNIT_TIME  = 0;
    localparam int UNIT_DATE  = 1;
    localparam int UNIT_ALARM = 2;
    localparam int UNIT_TIMER = 3;

    typedef enum logic {VIEW, EDIT} state_t;

    typedef enum logic [2:0] {
        BTN_NONE, BTN_ESC, BTN_ENTER, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT
    } btn_t;

    // b = {esc, enter, up, down, left, right}; highest-priority press wins
    function automatic btn_t pick_btn(logic [5:0] b);
        return b[5] ? BTN_ESC : b[4] ? BTN_ENTER : b[3] ? BTN_UP :
               b[2] ? BTN_DOWN : b[1] ? BTN_LEFT : b[0] ? BTN_RIGHT : BTN_NONE;
    endfunction

endpackage

// File: rtl/ui_sched_if.sv
// ui_sched_if: button inputs and unit-routing outputs of the front-panel scheduler.
interface ui_sched_if #(
    parameter int NUM_UNITS  = 4,
    parameter int NUM_FIELDS = 3
);
    logic                          up, down, left, right, enter, esc, tick;
    logic [$clog2(NUM_UNITS)-1:0]  unit_sel;
    logic [NUM_UNITS-1:0]          edit_en, commit, abort;
    logic [$clog2(NUM_FIELDS)-1:0] field;
    logic                          inc, dec, blink;

    modport master (
        output up, down, left, right, enter, esc, tick,
        input  unit_sel, edit_en, field, inc, dec, commit, abort, blink
    );

    modport slave (
        input  up, down, left, right, enter, esc, tick,
        output unit_sel, edit_en, field, inc, dec, commit, abort, blink
    );
endinterface

// File: rtl/ui_sched_idle_timer.sv
// idle_timer: counts ticks while enabled; expire pulses on the tick that reaches TIMEOUT_S.
module idle_timer #(
    parameter int TIMEOUT_S = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic tick,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_S + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // a coinciding clear beats the expiring tick
    assign expire = en && !clr && tick && (cnt_q == CW'(TIMEOUT_S - 1));

    always_comb begin
        cnt_d = (!en || clr || expire) ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/ui_sched.sv
// ui_sched: routes panel buttons to one unit and runs the VIEW/EDIT state machine.
// Define UI_AUTO_EXIT_EN to auto-abort an edit after TIMEOUT_S idle ticks.
module ui_sched
    import clock_pkg::*;
#(
    parameter int NUM_UNITS  = 4,
    parameter int NUM_FIELDS = 3
`ifdef UI_AUTO_EXIT_EN
    , parameter int TIMEOUT_S = 30
`endif
) (
    input logic       clk,
    input logic       rst,
    ui_sched_if.slave ui
);
    localparam int UW = $clog2(NUM_UNITS);
    localparam int FW = $clog2(NUM_FIELDS);
    localparam logic [UW-1:0] UMAX = UW'(NUM_UNITS - 1);
    localparam logic [FW-1:0] FMAX = FW'(NUM_FIELDS - 1);

    state_t               state_q, state_d;
    logic [UW-1:0]        unit_q, unit_d;
    logic [FW-1:0]        field_q, field_d;
    logic                 blink_q, blink_d, inc_q, inc_d, dec_q, dec_d;
    logic [NUM_UNITS-1:0] edit_en_q, edit_en_d, commit_q, commit_d, abort_q, abort_d;
    logic [NUM_UNITS-1:0] sel_oh;
    logic [5:0]           btns;
    btn_t                 btn;
    logic                 expire;

    assign btns   = {ui.esc, ui.enter, ui.up, ui.down, ui.left, ui.right};
    assign btn    = pick_btn(btns);
    assign sel_oh = NUM_UNITS'(1) << unit_q;

`ifdef UI_AUTO_EXIT_EN
    idle_timer #(.TIMEOUT_S(TIMEOUT_S)) u_idle (
        .clk    (clk),
        .rst    (rst),
        .en     (state_q == EDIT),
        .clr    (|btns),
        .tick   (ui.tick),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        unit_d   = unit_q;
        field_d  = field_q;
        blink_d  = blink_q;
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        commit_d = '0;
        abort_d  = '0;
        if (state_q == VIEW) begin
            if (btn == BTN_RIGHT) unit_d = (unit_q == UMAX) ? '0 : unit_q + 1'b1;
            if (btn == BTN_LEFT)  unit_d = (unit_q == '0) ? UMAX : unit_q - 1'b1;
            if (btn == BTN_ENTER) begin
                state_d = EDIT;
                field_d = '0;
                blink_d = 1'b1;
            end
        end else begin
            blink_d = ui.tick ? !blink_q : blink_q;
            inc_d   = (btn == BTN_UP);
            dec_d   = (btn == BTN_DOWN);
            if (btn == BTN_RIGHT) field_d = (field_q == FMAX) ? '0 : field_q + 1'b1;
            if (btn == BTN_LEFT)  field_d = (field_q == '0) ? FMAX : field_q - 1'b1;
            commit_d = (btn == BTN_ENTER) ? sel_oh : '0;
            abort_d  = (btn == BTN_ESC || expire) ? sel_oh : '0;
            if (btn == BTN_ENTER || btn == BTN_ESC || expire) begin
                state_d = VIEW;
                field_d = '0;
                blink_d = 1'b0;
            end
        end
        // edit_en tracks the next state so it drops together with commit/abort
        edit_en_d = (state_d == EDIT) ? (NUM_UNITS'(1) << unit_d) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= VIEW;
            unit_q    <= UW'(UNIT_TIME);
            field_q   <= '0;
            blink_q   <= 1'b0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            edit_en_q <= '0;
            commit_q  <= '0;
            abort_q   <= '0;
        end else begin
            state_q   <= state_d;
            unit_q    <= unit_d;
            field_q   <= field_d;
            blink_q   <= blink_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
            edit_en_q <= edit_en_d;
            commit_q  <= commit_d;
            abort_q   <= abort_d;
        end
    end

    assign ui.unit_sel = unit_q;
    assign ui.field    = field_q;
    assign ui.blink    = blink_q;
    assign ui.inc      = inc_q;
    assign ui.dec      = dec_q;
    assign ui.edit_en  = edit_en_q;
    assign ui.commit   = commit_q;
    assign ui.abort    = abort_q;
endmodule

// File: tb/tb_ui_sched.sv
// tb_ui_sched: table-driven scoreboard bench for ui_sched; timeout sequence under UI_AUTO_EXIT_EN.
module tb_ui_sched;
    import clock_pkg::*;

    typedef struct packed {
        logic [1:0] u;
        logic [3:0] ee;
        logic [1:0] f;
        logic       i, d;
        logic [3:0] c, a;
        logic       bl;
    } exp_t;

    typedef struct packed {
        logic [5:0] b;
        logic       t;
        exp_t       e;
    } vec_t;

    localparam logic [5:0] N = 6'b000000, R = 6'b000001, L = 6'b000010, D = 6'b000100;
    localparam logic [5:0] U = 6'b001000, E = 6'b010000, X = 6'b100000;
    localparam logic [3:0] OH_DATE = 4'b1 << UNIT_DATE, OH_TIMER = 4'b1 << UNIT_TIMER;
    localparam logic [3:0] OH_TIME = 4'b1 << UNIT_TIME;
    localparam logic [1:0] U_ALARM = 2'(UNIT_ALARM);

    logic clk = 1'b0, rst = 1'b1;
    int   passed = 0, total = 0;
    exp_t sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    ui_sched_if #(.NUM_UNITS(4), .NUM_FIELDS(3)) ui ();

    ui_sched #(
        .NUM_UNITS(4), .NUM_FIELDS(3)
`ifdef UI_AUTO_EXIT_EN
        , .TIMEOUT_S(3)
`endif
    ) dut (.clk(clk), .rst(rst), .ui(ui));

    function automatic vec_t v(logic [5:0] b, logic t, logic [1:0] u, logic [3:0] ee, logic [1:0] f,
                               logic i, logic d, logic [3:0] c, logic [3:0] a, logic bl);
        return '{b: b, t: t, e: '{u: u, ee: ee, f: f, i: i, d: d, c: c, a: a, bl: bl}};
    endfunction

    function automatic exp_t got();
        return '{u: ui.unit_sel, ee: ui.edit_en, f: ui.field, i: ui.inc, d: ui.dec,
                 c: ui.commit, a: ui.abort, bl: ui.blink};
    endfunction

    task automatic check(string name, exp_t act, exp_t req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got u=%0d ee=%b f=%0d inc=%b dec=%b c=%b a=%b bl=%b, want u=%0d ee=%b f=%0d inc=%b dec=%b c=%b a=%b bl=%b",
                      name, act.u, act.ee, act.f, act.i, act.d, act.c, act.a, act.bl,
                      req.u, req.ee, req.f, req.i, req.d, req.c, req.a, req.bl);
    endtask

    task automatic step(string name, vec_t vc);
        @(negedge clk);
        {ui.esc, ui.enter, ui.up, ui.down, ui.left, ui.right} = vc.b;
        ui.tick = vc.t;
        sb.push_back(vc.e);
        @(posedge clk);
        #1;
        {ui.esc, ui.enter, ui.up, ui.down, ui.left, ui.right, ui.tick} = '0;
        check(name, got(), sb.pop_front());
    endtask

    initial begin
        {ui.esc, ui.enter, ui.up, ui.down, ui.left, ui.right, ui.tick} = '0;
        // view navigation
        vecs.push_back(v(R, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(R, 0, U_ALARM, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(R, 0, 3, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(R, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(R, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(L, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(L, 0, 3, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(R, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(R, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // edit date unit, inc x3, field move, commit
        vecs.push_back(v(E, 0, 1, OH_DATE, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(U, 0, 1, OH_DATE, 0, 1, 0, 0, 0, 1));
        vecs.push_back(v(U, 0, 1, OH_DATE, 0, 1, 0, 0, 0, 1));
        vecs.push_back(v(U, 0, 1, OH_DATE, 0, 1, 0, 0, 0, 1));
        vecs.push_back(v(N, 0, 1, OH_DATE, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(R, 0, 1, OH_DATE, 1, 0, 0, 0, 0, 1));
        vecs.push_back(v(E, 0, 1, 0, 0, 0, 0, OH_DATE, 0, 0));
        vecs.push_back(v(N, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // field wrap both ways, esc
        vecs.push_back(v(E, 0, 1, OH_DATE, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(L, 0, 1, OH_DATE, 2, 0, 0, 0, 0, 1));
        vecs.push_back(v(L, 0, 1, OH_DATE, 1, 0, 0, 0, 0, 1));
        vecs.push_back(v(R, 0, 1, OH_DATE, 2, 0, 0, 0, 0, 1));
        vecs.push_back(v(R, 0, 1, OH_DATE, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(X, 0, 1, 0, 0, 0, 0, 0, OH_DATE, 0));
        vecs.push_back(v(N, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // simultaneous buttons
        vecs.push_back(v(E, 0, 1, OH_DATE, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(U | E, 0, 1, 0, 0, 0, 0, OH_DATE, 0, 0));
        vecs.push_back(v(E, 0, 1, OH_DATE, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(X | E, 0, 1, 0, 0, 0, 0, 0, OH_DATE, 0));
        // blink and tick alongside buttons
        vecs.push_back(v(N, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(E, 1, 1, OH_DATE, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(N, 1, 1, OH_DATE, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(U, 1, 1, OH_DATE, 0, 1, 0, 0, 0, 1));
        vecs.push_back(v(D, 0, 1, OH_DATE, 0, 0, 1, 0, 0, 1));
        vecs.push_back(v(E, 1, 1, 0, 0, 0, 0, OH_DATE, 0, 0));
        // view ignores up/down/esc; left beats right
        vecs.push_back(v(U, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(D, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(X, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(L | R, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(L, 0, 3, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(E, 0, 3, OH_TIMER, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(D | L, 0, 3, OH_TIMER, 0, 0, 1, 0, 0, 1));
        vecs.push_back(v(L | R, 0, 3, OH_TIMER, 2, 0, 0, 0, 0, 1));
        vecs.push_back(v(N, 0, 3, OH_TIMER, 2, 0, 0, 0, 0, 1));

        repeat (3) @(posedge clk);
        #1 check("reset_state", got(), '0);
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < vecs.size(); k++) step($sformatf("vec%0d", k), vecs[k]);

        // asynchronous reset mid-edit (unit 3, field 2)
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async", got(), '0);
        @(posedge clk);
        #1 check("rst_held", got(), '0);
        @(negedge clk) rst = 1'b0;
        step("post_rst_idle", v(N, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("post_rst_enter", v(E, 0, 0, OH_TIME, 0, 0, 0, 0, 0, 1));
        step("post_rst_esc", v(X, 0, 0, 0, 0, 0, 0, 0, OH_TIME, 0));

`ifdef UI_AUTO_EXIT_EN
        step("to_enter", v(E, 0, 0, OH_TIME, 0, 0, 0, 0, 0, 1));
        step("to_t1", v(N, 1, 0, OH_TIME, 0, 0, 0, 0, 0, 0));
        step("to_t2", v(N, 1, 0, OH_TIME, 0, 0, 0, 0, 0, 1));
        step("to_t3", v(N, 1, 0, 0, 0, 0, 0, 0, OH_TIME, 0));
        step("to_after", v(N, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("to2_enter", v(E, 0, 0, OH_TIME, 0, 0, 0, 0, 0, 1));
        step("to2_t1", v(N, 1, 0, OH_TIME, 0, 0, 0, 0, 0, 0));
        step("to2_t2_up", v(U, 1, 0, OH_TIME, 0, 1, 0, 0, 0, 1));
        step("to2_t3", v(N, 1, 0, OH_TIME, 0, 0, 0, 0, 0, 0));
        step("to2_t4", v(N, 1, 0, OH_TIME, 0, 0, 0, 0, 0, 1));
        step("to2_t5", v(N, 1, 0, 0, 0, 0, 0, 0, OH_TIME, 0));
`else
        step("noto_enter", v(E, 0, 0, OH_TIME, 0, 0, 0, 0, 0, 1));
        for (int k = 0; k < 40; k++)
            step($sformatf("noto_t%0d", k), v(N, 1, 0, OH_TIME, 0, 0, 0, 0, 0, k[0] ? 1'b1 : 1'b0));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ui_sched.md
# ui_sched

Front-panel scheduler for the clock project: owns the six shared push-buttons (up, down, left, right, enter, esc) and routes them to exactly one of the display/edit units (time, date, alarm, timer). It runs the view/edit state machine, tracks which field is under the cursor, and issues registered inc/dec/commit/abort pulses plus a one-hot edit enable that drives each unit's `mode` input. It sits between the button debouncers and the datapath units; the date unit is unit 1.

## Interface

- `NUM_UNITS`, 4: number of routed units; `unit_sel` width is `$clog2(NUM_UNITS)`.
- `NUM_FIELDS`, 3: editable fields per unit (e.g. year/month/day).
- `TIMEOUT_S`, 30: idle seconds before an edit is auto-aborted (used only with the macro below).

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `up`, `down`, `left`, `right`, `enter`, `esc`  in  1 each  debounced single-cycle button pulses.
- `tick`  in  1  1 Hz single-cycle pulse (the seconds carry).
- `unit_sel`  out  2  unit currently shown and owning the buttons.
- `edit_en`  out  NUM_UNITS  one-hot; bit `unit_sel` high while editing, otherwise all zero.
- `field`  out  2  cursor field index, 0..NUM_FIELDS-1.
- `inc`, `dec`  out  1 each  one-cycle pulse to the selected unit's field.
- `commit`, `abort`  out  NUM_UNITS each  one-hot single-cycle pulse on leaving EDIT.
- `blink`  out  1  toggles on each `tick` while editing; 0 in VIEW.

## Operation

- States: VIEW, EDIT.
- VIEW: `right` sets `unit_sel` to +1 and `left` sets it to −1, modulo NUM_UNITS (3→0, 0→3). `enter` → EDIT, `field`=0, `blink`=1. `up`, `down` and `esc` are ignored.
- EDIT: `right`/`left` move `field` ±1 modulo NUM_FIELDS. `up` pulses `inc`; `down` pulses `dec`. `unit_sel` is frozen.
- EDIT + `enter`: pulse `commit[unit_sel]` → VIEW. EDIT + `esc`: pulse `abort[unit_sel]` → VIEW. In both cases `field` is cleared to 0 and `blink` to 0.
- Simultaneous buttons: only the highest-priority button acts; the rest are dropped. Priority: esc > enter > up > down > left > right.
- `tick` coinciding with a button: both are processed. The blink toggle and the idle count advance independently of button handling.
- Reset (any time, including mid-edit): state VIEW, `unit_sel`=0, `field`=0, `blink`=0, all pulses 0. No commit or abort is issued.

## Timing

- All outputs are registered. A button pulse in cycle N produces its response in cycle N+1.
- `inc`, `dec`, `commit` and `abort` are high for exactly one cycle.
- `edit_en` rises in the same cycle the state register becomes EDIT. It falls in the same cycle that `commit` or `abort` is high, so units sample `commit` with `edit_en` already low.
- Back-to-back button pulses in consecutive cycles are each honoured; there is no dead time.

## Configuration

- `UI_AUTO_EXIT_EN` defined: an idle counter counts `tick`s while in EDIT and is cleared by any button pulse. When the count reaches TIMEOUT_S, `abort[unit_sel]` is pulsed and the state returns to VIEW on the next cycle. If a button and the expiring tick coincide, the button wins and the counter clears.
- Macro undefined: no counter exists; EDIT persists until `enter` or `esc`.

## Structure

- Shared package `clock_pkg` holds:
  - unit index constants UNIT_TIME=0, UNIT_DATE=1, UNIT_ALARM=2, UNIT_TIMER=3;
  - the state enum (VIEW, EDIT);
  - the button-priority order.
- One natural sub-module, `idle_timer`: tick counter with clear and expire output. It is instantiated only under `UI_AUTO_EXIT_EN`.

## Test plan

- Reset, then 5 `right` pulses → `unit_sel` steps 1, 2, 3, 0, 1. Then `left` ×2 → 0, then 3.
- `unit_sel`=1, `enter` → next cycle `edit_en`=4'b0010, `field`=0. `up` ×3 → three 1-cycle `inc` pulses. `right` → `field`=1. `enter` → `commit`=4'b0010 for one cycle, `edit_en`=0.
- In EDIT, `left` at `field`=0 → `field`=2. `esc` → `abort[unit_sel]` for one cycle, `field`=0, state VIEW.
- `up`+`enter` in the same cycle while editing → `commit` pulses, no `inc`. `esc`+`enter` → `abort` only.
- With `UI_AUTO_EXIT_EN` and TIMEOUT_S=3: enter EDIT, apply 3 ticks with no buttons → `abort` after the third tick. Repeat with `up` on the 2nd tick → no abort until 3 further ticks.
- Assert `rst` mid-EDIT with `field`=2 → all outputs 0 immediately (asynchronous), no `commit` or `abort` pulse, VIEW after release.
